// File: rtl/log2_mitchell_pkg.sv
// Shared softmax log-path constants: widths and the
// Mitchell correction table in Q0.16.
package log2_mitchell_pkg;

  localparam int OUTPUT_BUF_DATASIZE = 32;
  localparam int DEF_IN_SIZE = OUTPUT_BUF_DATASIZE;
  localparam int DEF_INT_W = 6;
  localparam int DEF_FRAC_W = 16;

  // Entry k sits at index k (rightmost is 0).
  localparam logic [7:0][15:0] CORR_Q16 = {
    16'd1094, 16'd2981, 16'd4416, 16'd5332,
    16'd5640, 16'd5231, 16'd3960, 16'd1636
  };

endpackage

// File: rtl/log2_corr_lut.sv
// Piecewise Mitchell correction, indexed by the top
// three fraction bits and scaled to FRAC_W.
module log2_corr_lut
  import log2_mitchell_pkg::*;
#(
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic [2:0]        idx,
  output logic [FRAC_W-1:0] corr
);

  logic [15:0] c16;

  assign c16 = CORR_Q16[idx];
  // Taking the top bits is the right shift by 16-FRAC_W.
  assign corr = c16[15 -: FRAC_W];

endmodule

// File: rtl/log2_mitchell.sv
// Two-stage pipelined log2 via Mitchell's approximation
// with 8-segment correction and valid/ready on both ends.
module log2_mitchell
  import log2_mitchell_pkg::*;
#(
  parameter int IN_SIZE = DEF_IN_SIZE,
  parameter int POS_W   = 32,
  parameter int INT_W   = DEF_INT_W,
  parameter int FRAC_W  = DEF_FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_SIZE-1:0]      in_data,
  input  logic [POS_W-1:0]        in_pos,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INT_W+FRAC_W-1:0] out_log,
  output logic                    out_zero
);

  localparam int OUT_W = INT_W + FRAC_W;
  localparam int SH_W  = 8;

  logic               va;
  logic [IN_SIZE-1:0] a_data;
  logic [5:0]         a_pos;
  logic [INT_W-1:0]   a_int;
  logic               a_zero;
  logic               load_a;
  logic               load_b;
  logic [IN_SIZE-1:0] lead;
  logic [IN_SIZE-1:0] shifted;
  logic [SH_W-1:0]    sh;
  logic [FRAC_W-1:0]  f;
  logic [FRAC_W-1:0]  corr_raw;
  logic [FRAC_W-1:0]  corr;
  logic [OUT_W-1:0]   sum;
  logic               unused_bits;

  assign in_ready = !va || !out_valid || out_ready;
  assign load_a   = in_valid && in_ready;
  assign load_b   = va && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va <= 1'b0;
    end else if (load_a) begin
      va <= 1'b1;
    end else if (load_b) begin
      va <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_a) begin
      a_data <= in_data;
      a_pos  <= in_pos[5:0];
      a_int  <= INT_W'(in_pos[5:0] - 6'd1);
      a_zero <= (in_pos == '0);
    end
  end

  // Drop the leading one, then align the next bit to the MSB.
  assign lead    = {{(IN_SIZE-1){1'b0}}, 1'b1} << a_int;
  assign sh      = SH_W'(IN_SIZE + 1) - SH_W'(a_pos);
  assign shifted = (a_data & ~lead) << sh;
  assign f       = shifted[IN_SIZE-1 -: FRAC_W];

  log2_corr_lut #(
    .FRAC_W(FRAC_W)
  ) u_lut (
    .idx (f[FRAC_W-1 -: 3]),
    .corr(corr_raw)
  );

  // Exact powers of two stay exact.
  assign corr = (f == '0) ? '0 : corr_raw;
  assign sum  = {a_int, f} + OUT_W'(corr);

  assign unused_bits = ^shifted[IN_SIZE-FRAC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_log   <= '0;
      out_zero  <= 1'b0;
    end else if (load_b) begin
      out_valid <= 1'b1;
      out_log   <= a_zero ? '0 : sum;
      out_zero  <= a_zero;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_log2_mitchell.sv
// Directed-vector and streaming bench for log2_mitchell.
// Expected values come from hand tables and a float-free model.
module tb_log2_mitchell;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_pos;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] out_log;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pos;
    logic [21:0] exp_log;
    logic        exp_zero;
  } vec_t;

  vec_t vt[9];

  log2_mitchell dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_pos   (in_pos),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_log  (out_log),
    .out_zero (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ldpos(input logic [31:0] x);
    logic [31:0] p;
    p = 0;
    for (int i = 0; i < 32; i++)
      if (x[i]) p = 32'(i + 1);
    return p;
  endfunction

  // Reference: f = floor((x/2^(p-1) - 1) * 2^16), plus table correction.
  function automatic logic [22:0] model(input logic [31:0] x);
    int          tab[8];
    logic [31:0] p;
    logic [63:0] rem;
    logic [63:0] fl;
    int          c;
    tab = '{1636, 3960, 5231, 5640, 5332, 4416, 2981, 1094};
    p = ldpos(x);
    if (p == 0) return {1'b1, 22'd0};
    rem = 64'(x) - (64'd1 << (p - 1));
    fl  = (rem << 16) >> (p - 1);
    c   = (fl == 0) ? 0 : tab[fl[15:13]];
    return {1'b0, 22'((p - 1) * 65536 + fl + 64'(c))};
  endfunction

  task automatic run_one(input string name, input vec_t v);
    bit lat_ok;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = v.data;
    in_pos    = v.pos;
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    lat_ok = !out_valid;
    @(negedge clk);
    lat_ok = lat_ok && out_valid;
    chk({name, "_latency"}, 32'(lat_ok), 32'd1);
    chk({name, "_log"}, 32'(out_log), 32'(v.exp_log));
    chk({name, "_zero"}, 32'(out_zero), 32'(v.exp_zero));
  endtask

  task automatic run_stream(input int n);
    logic [31:0] ops[$];
    logic [22:0] expq[$];
    logic [22:0] e;
    int sent, got, cyc, inflight, acc, drn;
    bit hold_pend;
    logic [21:0] hl;
    logic hz;
    sent = 0; got = 0; cyc = 0; inflight = 0; hold_pend = 0;
    hl = '0; hz = 1'b0;
    for (int i = 0; i < n; i++)
      ops.push_back($urandom >> $urandom_range(0, 31));
    ops[0] = 32'hFFFF_FFFF;
    ops[5] = 32'd0;
    ops[6] = 32'd1;
    while (got < n && cyc < 400) begin
      @(posedge clk); #1;
      out_ready = (cyc % 3) != 2;
      if (sent < n) begin
        in_valid = 1'b1;
        in_data  = ops[sent];
        in_pos   = ldpos(ops[sent]);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (hold_pend)
        chk("stall_hold", {9'd0, out_valid, out_zero, out_log},
            {9'd0, 1'b1, hz, hl});
      chk("in_ready", 32'(in_ready),
          32'(!(inflight == 2 && !out_ready)));
      drn = 0;
      if (out_valid && out_ready) begin
        drn = 1;
        if (expq.size() == 0) begin
          chk("stream_dup", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("stream_log", 32'(out_log), 32'(e[21:0]));
          chk("stream_zero", 32'(out_zero), 32'(e[22]));
        end
        got++;
      end
      hold_pend = out_valid && !out_ready;
      hl = out_log;
      hz = out_zero;
      acc = (in_valid && in_ready) ? 1 : 0;
      if (acc == 1) begin
        expq.push_back(model(ops[sent]));
        sent++;
      end
      inflight = inflight + acc - drn;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", 32'(got), 32'(n));
    chk("stream_left", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int stale;
    vt[0] = '{32'd8,          32'd4,  22'd196608,  1'b0};
    vt[1] = '{32'd12,         32'd4,  22'd234708,  1'b0};
    vt[2] = '{32'hFFFF_FFFF,  32'd32, 22'd2098245, 1'b0};
    vt[3] = '{32'd1,          32'd1,  22'd0,       1'b0};
    vt[4] = '{32'd0,          32'd0,  22'd0,       1'b1};
    vt[5] = '{32'd3,          32'd2,  22'd103636,  1'b0};
    vt[6] = '{32'd5,          32'd3,  22'd152687,  1'b0};
    vt[7] = '{32'd7,          32'd3,  22'd183205,  1'b0};
    vt[8] = '{32'h8000_0000,  32'd32, 22'd2031616, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_pos = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_log", 32'(out_log), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++)
      run_one($sformatf("vec%0d", i), vt[i]);

    run_stream(16);

    // Fill both stages, then reset mid-flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'd8;
    in_pos = 32'd4;
    @(posedge clk); #1;
    in_data = 32'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst_no_stale", 32'(stale), 32'd0);
    run_one("post_rst", vt[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
